rc4_prga_fsm: RTL and testbench

RC4_PRGA_FSM -- requirements
Module: rc4_prga_fsm

---
 rtl/rc4_prga_fsm.sv | 163 ++++++++++++++++
 tb/tb_rc4_prga_fsm.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_fsm.sv
`default_nettype none
// ============================================================================
// Module   : rc4_prga_fsm
// Purpose  : RC4 keystream generator and decryptor. It swaps S[i]/S[j], reads
//            S[S[i]+S[j]] and XORs the result with the encrypted ROM byte.
// Revision : 1.0
// ============================================================================
module rc4_prga_fsm #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [4:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [4:0] dec_address,
  output logic [7:0] dec_data,
  output logic       dec_wren,
  output logic       done
);

  localparam logic [4:0] C_LAST_K = 5'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_SI   = 4'd1,
    ST_WAIT_SI = 4'd2,
    ST_CAP_SI  = 4'd3,
    ST_RD_SJ   = 4'd4,
    ST_WAIT_SJ = 4'd5,
    ST_CAP_SJ  = 4'd6,
    ST_WR_SI   = 4'd7,
    ST_WR_SJ   = 4'd8,
    ST_RD_F    = 4'd9,
    ST_WAIT_F  = 4'd10,
    ST_WR_DEC  = 4'd11,
    ST_NEXT    = 4'd12,
    ST_DONE    = 4'd13
  } state_t;

  state_t     r_state, w_next;
  logic [7:0] r_i, r_j, r_si, r_sj, r_f;
  logic [4:0] r_k;
  logic [7:0] w_f;
  logic [7:0] w_f_idx;

  assign w_f_idx = r_si + r_sj;
  assign done    = (r_state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_f     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_i <= 8'd1;
            r_j <= '0;
            r_k <= '0;
          end
        end
        ST_CAP_SI: begin
          r_si <= s_q;
          r_j  <= r_j + s_q;
        end
        ST_CAP_SJ: r_sj <= s_q;
        ST_WR_DEC: r_f  <= s_q;
        ST_NEXT: begin
          if (r_k != C_LAST_K) begin
            r_k <= r_k + 5'd1;
            r_i <= r_i + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read addresses are held through the wait state so s_q stays valid at capture.
  always_comb begin
    w_next      = r_state;
    s_address   = '0;
    s_data      = '0;
    s_wren      = 1'b0;
    rom_address = '0;
    dec_address = '0;
    dec_data    = '0;
    dec_wren    = 1'b0;
    w_f         = r_f;

    if (r_state != ST_IDLE && r_state != ST_NEXT && r_state != ST_DONE)
      rom_address = r_k;

    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_RD_SI;
      end
      ST_RD_SI: begin
        s_address = r_i;
        w_next    = ST_WAIT_SI;
      end
      ST_WAIT_SI: begin
        s_address = r_i;
        w_next    = ST_CAP_SI;
      end
      ST_CAP_SI: w_next = ST_RD_SJ;
      ST_RD_SJ: begin
        s_address = r_j;
        w_next    = ST_WAIT_SJ;
      end
      ST_WAIT_SJ: begin
        s_address = r_j;
        w_next    = ST_CAP_SJ;
      end
      ST_CAP_SJ: w_next = ST_WR_SI;
      ST_WR_SI: begin
        s_address = r_i;
        s_data    = r_sj;
        s_wren    = 1'b1;
        w_next    = ST_WR_SJ;
      end
      ST_WR_SJ: begin
        s_address = r_j;
        s_data    = r_si;
        s_wren    = 1'b1;
        w_next    = ST_RD_F;
      end
      ST_RD_F: begin
        s_address = w_f_idx;
        w_next    = ST_WAIT_F;
      end
      ST_WAIT_F: begin
        s_address = w_f_idx;
        w_next    = ST_WR_DEC;
      end
      ST_WR_DEC: begin
        w_f         = s_q;
        dec_address = r_k;
        dec_data    = w_f ^ rom_q;
        dec_wren    = 1'b1;
        w_next      = ST_NEXT;
      end
      ST_NEXT: begin
        w_next = (r_k == C_LAST_K) ? ST_DONE : ST_RD_SI;
      end
      ST_DONE: w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc4_prga_fsm
// Purpose  : Directed bench for rc4_prga_fsm with synchronous RAM/ROM models
//            and a software RC4 reference (instances with MSG_LEN 32 and 9).
// Revision : 1.0
// ============================================================================
module tb_rc4_prga_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  // Instance A: MSG_LEN = 32
  logic       rst_a, start_a, load_a;
  logic [7:0] sa_addr, sa_data, sa_q, ra_q, da_data;
  logic [4:0] ra_addr, da_addr;
  logic       sa_wren, da_wren, done_a;
  logic [7:0] sa [256];
  logic [7:0] roma [32];
  logic [7:0] deca [32];
  int wr_s_a = 0;
  int wr_d_a = 0;
  int wr1_a  = 0;

  // Instance B: MSG_LEN = 9
  logic       rst_b, start_b, load_b;
  logic [7:0] sb_addr, sb_data, sb_q, rb_q, db_data;
  logic [4:0] rb_addr, db_addr;
  logic       sb_wren, db_wren, done_b;
  logic [7:0] sb [256];
  logic [7:0] romb [32];
  logic [7:0] decb [32];
  int wr_b = 0;

  // Preload images and reference model state
  logic [7:0] ia_s [256];
  logic [7:0] ia_rom [32];
  logic [7:0] m_s [256];
  logic [7:0] m_ks [32];

  rc4_prga_fsm #(.MSG_LEN(32)) u_dut_a (
    .clk(clk), .reset(rst_a), .start(start_a),
    .s_address(sa_addr), .s_data(sa_data), .s_wren(sa_wren), .s_q(sa_q),
    .rom_address(ra_addr), .rom_q(ra_q),
    .dec_address(da_addr), .dec_data(da_data), .dec_wren(da_wren),
    .done(done_a)
  );

  rc4_prga_fsm #(.MSG_LEN(9)) u_dut_b (
    .clk(clk), .reset(rst_b), .start(start_b),
    .s_address(sb_addr), .s_data(sb_data), .s_wren(sb_wren), .s_q(sb_q),
    .rom_address(rb_addr), .rom_q(rb_q),
    .dec_address(db_addr), .dec_data(db_data), .dec_wren(db_wren),
    .done(done_b)
  );

  always @(posedge clk) begin
    if (load_a) begin
      sa   <= ia_s;
      roma <= ia_rom;
      deca <= '{default: 8'h00};
    end else begin
      if (sa_wren) sa[sa_addr] <= sa_data;
      if (da_wren) deca[da_addr] <= da_data;
    end
    sa_q <= sa[sa_addr];
    ra_q <= roma[ra_addr];
    if (sa_wren) wr_s_a <= wr_s_a + 1;
    if (da_wren) wr_d_a <= wr_d_a + 1;
    if (sa_wren && sa_addr == 8'd1) wr1_a <= wr1_a + 1;
  end

  always @(posedge clk) begin
    if (load_b) begin
      sb   <= ia_s;
      romb <= ia_rom;
      decb <= '{default: 8'h00};
    end else begin
      if (sb_wren) sb[sb_addr] <= sb_data;
      if (db_wren) decb[db_addr] <= db_data;
    end
    sb_q <= sb[sb_addr];
    rb_q <= romb[rb_addr];
    if (sb_wren || db_wren) wr_b <= wr_b + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_identity();
    for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
  endtask

  task automatic model_ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
    logic [7:0] j, t, kb;
    model_identity();
    j = 8'd0;
    for (int x = 0; x < 256; x++) begin
      kb = (x % 3 == 0) ? k0 : ((x % 3 == 1) ? k1 : k2);
      j = j + m_s[x] + kb;
      t = m_s[x];
      m_s[x] = m_s[j];
      m_s[j] = t;
    end
  endtask

  // Standard RC4 PRGA: i increments before use, so the first i is 1.
  task automatic model_prga(input int n);
    logic [7:0] i, j, t, idx;
    i = 8'd0;
    j = 8'd0;
    for (int k = 0; k < n; k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      t = m_s[i];
      m_s[i] = m_s[j];
      m_s[j] = t;
      idx = m_s[i] + m_s[j];
      m_ks[k] = m_s[idx];
    end
  endtask

  task automatic load_a_mem();
    @(negedge clk) load_a = 1'b1;
    @(negedge clk) load_a = 1'b0;
  endtask

  task automatic load_b_mem();
    @(negedge clk) load_b = 1'b1;
    @(negedge clk) load_b = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    while (!done_a && cyc < budget) step();
  endtask

  initial begin
    logic [7:0] cipher [9];
    logic [7:0] plain  [9];
    int w0, w1, wd, diffs;

    cipher = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    plain  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    load_a = 1'b0; load_b = 1'b0;

    // ---- Identity S, ROM all zero ----
    for (int x = 0; x < 256; x++) ia_s[x] = 8'(x);
    for (int k = 0; k < 32; k++) ia_rom[k] = 8'h00;
    load_a_mem();
    chk("reset_outputs", {sa_addr, sa_data, sa_wren, ra_addr, da_addr, da_data, da_wren, done_a}, 64'd0);

    @(negedge clk) rst_a = 1'b0;
    @(negedge clk);
    chk("idle_no_start_outputs", {sa_addr, sa_wren, ra_addr, da_wren, done_a}, 64'd0);
    w0 = wr_s_a; w1 = wr1_a; wd = wr_d_a;
    start_a = 1'b1;
    cyc = 0;
    step();
    chk("byte0_rd_si_addr", {ra_addr, sa_addr}, {5'd0, 8'd1});
    while (cyc < 12) step();
    chk("byte0_collision_writes_at_1", wr1_a - w1, 2);
    chk("byte0_s_write_count", wr_s_a - w0, 2);
    chk("byte0_dec_write_count", wr_d_a - wd, 1);
    chk("byte0_s1_unchanged", sa[1], 8'h01);
    chk("byte0_dec0", deca[0], 8'h02);
    while (cyc < 24) step();
    chk("byte1_s2", sa[2], 8'h03);
    chk("byte1_s3", sa[3], 8'h02);
    chk("byte1_dec1", deca[1], 8'h05);
    wait_done_a(500);
    chk("identity_done_cycle", cyc, 385);
    model_identity();
    model_prga(32);
    diffs = 0;
    for (int k = 0; k < 32; k++) if (deca[k] !== m_ks[k]) diffs++;
    chk("identity_all_dec_bytes_diffs", diffs, 0);

    // ---- Long run: KSA("Key") S, patterned ROM ----
    start_a = 1'b0;
    @(negedge clk) rst_a = 1'b1;
    model_ksa(8'h4B, 8'h65, 8'h79);
    ia_s = m_s;
    for (int k = 0; k < 32; k++) ia_rom[k] = 8'(k * 37 + 11);
    load_a_mem();
    @(negedge clk) rst_a = 1'b0;
    start_a = 1'b1;
    cyc = 0;
    step();
    wait_done_a(500);
    chk("long_done_cycle", cyc, 385);
    model_prga(32);
    for (int k = 0; k < 32; k++)
      chk($sformatf("long_dec%0d", k), deca[k], ia_rom[k] ^ m_ks[k]);
    diffs = 0;
    for (int x = 0; x < 256; x++) if (sa[x] !== m_s[x]) diffs++;
    chk("long_final_s_diffs", diffs, 0);

    // ---- Reset in WAIT_SJ of byte 5, start held ----
    @(negedge clk) rst_a = 1'b1;
    for (int x = 0; x < 256; x++) ia_s[x] = 8'(x);
    for (int k = 0; k < 32; k++) ia_rom[k] = 8'h00;
    load_a_mem();
    @(negedge clk) rst_a = 1'b0;
    cyc = 0;
    while (cyc < 65) step();
    chk("pre_reset_byte5_rom_addr", {ra_addr, sa_wren, da_wren}, {5'd5, 1'b0, 1'b0});
    #2 rst_a = 1'b1;
    #1;
    chk("async_reset_outputs", {sa_addr, sa_data, sa_wren, ra_addr, da_addr, da_data, da_wren, done_a}, 64'd0);
    @(negedge clk) rst_a = 1'b0;
    cyc = 0;
    step();
    chk("restart_rd_si_addr", {ra_addr, sa_addr}, {5'd0, 8'd1});
    wait_done_a(500);
    chk("restart_done_cycle", cyc, 385);
    model_identity();
    model_prga(5);
    model_prga(32);
    diffs = 0;
    for (int k = 0; k < 32; k++) if (deca[k] !== m_ks[k]) diffs++;
    chk("restart_dec_diffs", diffs, 0);
    start_a = 1'b0;

    // ---- Instance B: KSA("Key"), "Plaintext", single-cycle start ----
    model_ksa(8'h4B, 8'h65, 8'h79);
    ia_s = m_s;
    for (int k = 0; k < 32; k++) ia_rom[k] = (k < 9) ? cipher[k] : 8'h00;
    load_b_mem();
    @(negedge clk) rst_b = 1'b0;
    @(negedge clk) start_b = 1'b1;
    cyc = 0;
    step();
    start_b = 1'b0;
    while (!done_b && cyc < 300) step();
    chk("ksa_done_cycle", cyc, 109);
    for (int k = 0; k < 9; k++)
      chk($sformatf("ksa_dec%0d", k), decb[k], plain[k]);

    w0 = wr_b;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_done_no_writes", wr_b - w0, 0);
    chk("post_done_sticky", {done_b, sb_wren, db_wren, sb_addr}, {1'b1, 1'b0, 1'b0, 8'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
